// File: rtl/bcd_counter2_pkg.sv
// rtl/bcd_counter2_pkg.sv - shared BCD constants, digit-pair type and modulo digit helpers
package bcd_counter2_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Two BCD digits as shown on HEX1/HEX0
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_pair_t;

  // Tens digit of the highest legal count (modulo-1)
  function automatic logic [3:0] last_tens(input int modulo);
    return 4'((modulo - 1) / 10);
  endfunction

  // Units digit of the highest legal count (modulo-1)
  function automatic logic [3:0] last_units(input int modulo);
    return 4'((modulo - 1) % 10);
  endfunction

endpackage

// File: rtl/bcd_counter2_if.sv
// rtl/bcd_counter2_if.sv - control and display bundle of the two-digit BCD counter
interface bcd_counter2_if;

  logic       En;
  logic       Up;
  logic       Load;
  logic [7:0] LoadVal;
  logic [3:0] D0;
  logic [3:0] D1;
  logic       Wrap;
  logic       LoadErr;
  logic       Tick;

  modport master (
    output En, Up, Load, LoadVal,
    input  D0, D1, Wrap, LoadErr, Tick
  );

  modport slave (
    input  En, Up, Load, LoadVal,
    output D0, D1, Wrap, LoadErr, Tick
  );

endinterface

// File: rtl/bcd_counter2_tick_gen.sv
// rtl/bcd_counter2_tick_gen.sv - prescaler producing a registered one-cycle Tick every TICK_DIV enabled cycles
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic En,
  input  logic Clr,
  output logic Fire,
  output logic Tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_pre;
  logic          r_tick;

  // Fire is the edge on which a step happens; Tick shows it during the following cycle
  assign Fire = En && (r_pre == LAST);
  assign Tick = r_tick;

  // Prescaler: wraps on Fire, clears on Clr (a load), freezes while En is low
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= Fire && !Clr;
      if (Clr || Fire) begin
        r_pre <= '0;
      end else if (En) begin
        r_pre <= r_pre + CW'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_counter2.sv
// rtl/bcd_counter2.sv - two-digit BCD up/down counter with load validation and programmable modulo
module bcd_counter2
  import bcd_counter2_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int MODULO   = 100
) (
  input  logic Clock,
  input  logic Reset,
  bcd_counter2_if.slave bus
);

  localparam logic [3:0] MOD_TENS  = last_tens(MODULO);
  localparam logic [3:0] MOD_UNITS = last_units(MODULO);

  bcd_pair_t r_cnt;
  logic      r_wrap;
  logic      r_loaderr;
  bcd_pair_t w_lv;
  logic      w_load_ok;
  logic      w_fire;

  assign w_lv = bcd_pair_t'(bus.LoadVal);

  // Load accepted only for two valid BCD digits forming a value below MODULO
  assign w_load_ok = (w_lv.units <= BCD_MAX) && (w_lv.tens <= BCD_MAX) &&
                     ((w_lv.tens < MOD_TENS) ||
                      ((w_lv.tens == MOD_TENS) && (w_lv.units <= MOD_UNITS)));

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .Clock (Clock),
    .Reset (Reset),
    .En    (bus.En),
    .Clr   (bus.Load),
    .Fire  (w_fire),
    .Tick  (bus.Tick)
  );

  assign bus.D0      = r_cnt.units;
  assign bus.D1      = r_cnt.tens;
  assign bus.Wrap    = r_wrap;
  assign bus.LoadErr = r_loaderr;

  // Digit register: load beats a step, steps carry/borrow digit by digit and wrap at MODULO
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_cnt     <= '{tens: BCD_ZERO, units: BCD_ZERO};
      r_wrap    <= 1'b0;
      r_loaderr <= 1'b0;
    end else begin
      r_wrap    <= 1'b0;
      r_loaderr <= 1'b0;
      if (bus.Load) begin
        if (w_load_ok) begin
          r_cnt <= w_lv;
        end else begin
          r_loaderr <= 1'b1;
        end
      end else if (w_fire) begin
        if (bus.Up) begin
          if ((r_cnt.tens == MOD_TENS) && (r_cnt.units == MOD_UNITS)) begin
            r_cnt  <= '{tens: BCD_ZERO, units: BCD_ZERO};
            r_wrap <= 1'b1;
          end else if (r_cnt.units == BCD_MAX) begin
            r_cnt.units <= BCD_ZERO;
            r_cnt.tens  <= r_cnt.tens + 4'd1;
          end else begin
            r_cnt.units <= r_cnt.units + 4'd1;
          end
        end else begin
          if ((r_cnt.tens == BCD_ZERO) && (r_cnt.units == BCD_ZERO)) begin
            r_cnt  <= '{tens: MOD_TENS, units: MOD_UNITS};
            r_wrap <= 1'b1;
          end else if (r_cnt.units == BCD_ZERO) begin
            r_cnt.units <= BCD_MAX;
            r_cnt.tens  <= r_cnt.tens - 4'd1;
          end else begin
            r_cnt.units <= r_cnt.units - 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter2.sv
// tb/tb_bcd_counter2.sv - self-checking bench for bcd_counter2 (TICK_DIV=4/MODULO=60 and TICK_DIV=1/MODULO=100)
module tb_bcd_counter2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bcd_counter2_if ifa();
  bcd_counter2_if ifb();

  bcd_counter2 #(.TICK_DIV(4), .MODULO(60)) dut_a (
    .Clock (clk),
    .Reset (rst),
    .bus   (ifa)
  );

  bcd_counter2 #(.TICK_DIV(1), .MODULO(100)) dut_b (
    .Clock (clk),
    .Reset (rst),
    .bus   (ifb)
  );

  typedef struct {
    int val;
    int pre;
    bit tick;
    bit wrap;
    bit err;
  } model_t;

  typedef struct {
    logic [7:0] lv;
    int         d1;
    int         d0;
    int         err;
  } load_vec_t;

  int     vectors = 0;
  int     miscompares = 0;
  model_t ma, mb;

  // Count value kept as a plain integer; digits are derived only when comparing
  function automatic model_t model_step(model_t s, bit en, bit up, bit load,
                                        logic [7:0] lv, int td, int m);
    model_t n;
    int t, u;
    n = s;
    n.tick = 0;
    n.wrap = 0;
    n.err  = 0;
    t = int'(lv[7:4]);
    u = int'(lv[3:0]);
    if (load) begin
      n.pre = 0;
      if (t <= 9 && u <= 9 && (10 * t + u) < m) n.val = 10 * t + u;
      else n.err = 1;
    end else if (en) begin
      if (s.pre == td - 1) begin
        n.pre  = 0;
        n.tick = 1;
        if (up) begin
          n.wrap = (s.val == m - 1);
          n.val  = (s.val + 1) % m;
        end else begin
          n.wrap = (s.val == 0);
          n.val  = (s.val + m - 1) % m;
        end
      end else begin
        n.pre = s.pre + 1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("a_d0", int'(ifa.D0), ma.val % 10);
    chk("a_d1", int'(ifa.D1), ma.val / 10);
    chk("a_tick", int'(ifa.Tick), int'(ma.tick));
    chk("a_wrap", int'(ifa.Wrap), int'(ma.wrap));
    chk("a_loaderr", int'(ifa.LoadErr), int'(ma.err));
    chk("a_d0_is_bcd", int'(ifa.D0 <= 4'd9), 1);
    chk("a_below_modulo", int'(10 * int'(ifa.D1) + int'(ifa.D0) < 60), 1);
    chk("b_d0", int'(ifb.D0), mb.val % 10);
    chk("b_d1", int'(ifb.D1), mb.val / 10);
    chk("b_tick", int'(ifb.Tick), int'(mb.tick));
    chk("b_wrap", int'(ifb.Wrap), int'(mb.wrap));
    chk("b_loaderr", int'(ifb.LoadErr), int'(mb.err));
  endtask

  // One clock: model consumes the inputs present at the edge, outputs checked 1 time unit later
  task automatic cyc();
    @(posedge clk);
    ma = model_step(ma, ifa.En, ifa.Up, ifa.Load, ifa.LoadVal, 4, 60);
    mb = model_step(mb, ifb.En, ifb.Up, ifb.Load, ifb.LoadVal, 1, 100);
    #1;
    compare_all();
  endtask

  task automatic wait_tick_a(input int maxc, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!ifa.Tick && n < maxc);
    chk("a_tick_seen", int'(ifa.Tick), 1);
  endtask

  // Reset raised between edges: outputs must clear without waiting for a clock
  task automatic reset_mid();
    #3;
    rst = 1'b1;
    #1;
    ma = '{0, 0, 0, 0, 0};
    mb = '{0, 0, 0, 0, 0};
    compare_all();
    #3;
    rst = 1'b0;
  endtask

  task automatic load_a(input logic [7:0] v);
    ifa.Load = 1'b1;
    ifa.LoadVal = v;
    cyc();
    ifa.Load = 1'b0;
  endtask

  load_vec_t lt[8];
  int n;
  int wraps;

  initial begin
    lt[0] = '{8'h58, 5, 8, 0};
    lt[1] = '{8'h6A, 5, 8, 1};
    lt[2] = '{8'h1C, 5, 8, 1};
    lt[3] = '{8'h60, 5, 8, 1};
    lt[4] = '{8'h59, 5, 9, 0};
    lt[5] = '{8'h00, 0, 0, 0};
    lt[6] = '{8'h5F, 0, 0, 1};
    lt[7] = '{8'h45, 4, 5, 0};

    ifa.En = 0; ifa.Up = 1; ifa.Load = 0; ifa.LoadVal = 8'h00;
    ifb.En = 0; ifb.Up = 1; ifb.Load = 0; ifb.LoadVal = 8'h00;
    ma = '{0, 0, 0, 0, 0};
    mb = '{0, 0, 0, 0, 0};

    #1 rst = 1'b1;
    #2 compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Count up from reset: first tick after 4 enabled edges, then every 4
    ifa.En = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      wait_tick_a(10, n);
      chk("a_tick_spacing", n, 4);
      chk("a_count_up", 10 * int'(ifa.D1) + int'(ifa.D0), k);
    end

    // 58 -> 59 -> 00 with Wrap and Tick together
    load_a(8'h58);
    chk("a_load58", 10 * int'(ifa.D1) + int'(ifa.D0), 58);
    wait_tick_a(10, n);
    chk("a_59", 10 * int'(ifa.D1) + int'(ifa.D0), 59);
    chk("a_59_nowrap", int'(ifa.Wrap), 0);
    wait_tick_a(10, n);
    chk("a_wrap_to_00", 10 * int'(ifa.D1) + int'(ifa.D0), 0);
    chk("a_wrap_with_tick", int'(ifa.Wrap & ifa.Tick), 1);
    cyc();
    chk("a_wrap_one_cycle", int'(ifa.Wrap), 0);

    // Down: 00 -> 59 with Wrap, then 50 -> 49 borrow
    ifa.Up = 1'b0;
    wait_tick_a(10, n);
    chk("a_down_wrap_59", 10 * int'(ifa.D1) + int'(ifa.D0), 59);
    chk("a_down_wrap", int'(ifa.Wrap), 1);
    load_a(8'h50);
    wait_tick_a(10, n);
    chk("a_borrow_49", 10 * int'(ifa.D1) + int'(ifa.D0), 49);
    chk("a_borrow_nowrap", int'(ifa.Wrap), 0);

    // Load table with counting stopped
    ifa.En = 1'b0;
    for (int i = 0; i < 8; i++) begin
      load_a(lt[i].lv);
      chk("tbl_d1", int'(ifa.D1), lt[i].d1);
      chk("tbl_d0", int'(ifa.D0), lt[i].d0);
      chk("tbl_loaderr", int'(ifa.LoadErr), lt[i].err);
      cyc();
      chk("tbl_loaderr_clear", int'(ifa.LoadErr), 0);
    end

    // Load on the tick edge: loaded value wins, no step, no wrap
    ifa.En = 1'b1;
    ifa.Up = 1'b1;
    load_a(8'h59);
    repeat (3) cyc();
    load_a(8'h25);
    chk("coinc_val", 10 * int'(ifa.D1) + int'(ifa.D0), 25);
    chk("coinc_tick", int'(ifa.Tick), 0);
    chk("coinc_wrap", int'(ifa.Wrap), 0);

    // En low for 7 cycles mid-period: 4 active cycles between ticks
    load_a(8'h00);
    repeat (2) cyc();
    ifa.En = 1'b0;
    repeat (7) cyc();
    chk("en_low_held", 10 * int'(ifa.D1) + int'(ifa.D0), 0);
    ifa.En = 1'b1;
    wait_tick_a(10, n);
    chk("en_gap_active", 2 + n, 4);
    chk("en_gap_count", 10 * int'(ifa.D1) + int'(ifa.D0), 1);

    // Async reset mid-operation, first tick 4 edges after release
    reset_mid();
    wait_tick_a(10, n);
    chk("post_reset_tick", n, 4);

    // Random stimulus on both counters
    for (int i = 0; i < 500; i++) begin
      ifa.En = ($urandom_range(0, 9) != 0);
      ifa.Up = $urandom_range(0, 1);
      ifa.Load = ($urandom_range(0, 15) == 0);
      ifa.LoadVal = ($urandom_range(0, 1) != 0) ?
                    {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))} : 8'($urandom);
      ifb.En = ($urandom_range(0, 9) != 0);
      ifb.Up = $urandom_range(0, 1);
      ifb.Load = ($urandom_range(0, 15) == 0);
      ifb.LoadVal = ($urandom_range(0, 1) != 0) ?
                    {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))} : 8'($urandom);
      cyc();
    end

    // TICK_DIV=1, MODULO=100: 200 steps give exactly 2 wraps
    ifa.En = 0; ifa.Load = 0;
    ifb.En = 0; ifb.Load = 0;
    reset_mid();
    ifb.En = 1'b1;
    ifb.Up = 1'b1;
    wraps = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (ifb.Wrap) wraps++;
      if (i == 98) chk("b_99", 10 * int'(ifb.D1) + int'(ifb.D0), 99);
    end
    chk("b_wrap_count", wraps, 2);
    chk("b_final", 10 * int'(ifb.D1) + int'(ifb.D0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_counter2.md
Name: bcd_counter2

Overview:
Two-digit BCD up/down counter with a built-in tick prescaler. It produces the two BCD nibbles that drive a pair of b2d_7seg decoders, which show the count on HEX1 and HEX0. It is used for lab stopwatch and minute-counter displays: the counter steps once per prescaled tick, can be loaded from the switches, and wraps at a programmable modulo.

Parameters:
TICK_DIV, 50000000, number of Clock cycles per count step (1 Hz at 50 MHz); legal range >= 1.
MODULO, 100, count range is 0..MODULO-1; legal range 2..100.

Ports:
Clock  input  1  system clock; all state updates on its rising edge.
Reset  input  1  asynchronous, active-high reset.
En  input  1  1 = prescaler runs and the counter steps; 0 = everything holds.
Up  input  1  1 = count up, 0 = count down; sampled on the tick cycle.
Load  input  1  synchronous load strobe, level-sensitive.
LoadVal  input  8  load value; [7:4] is the tens BCD digit, [3:0] is the units BCD digit.
D0  output  4  units BCD digit, feeds the HEX0 decoder.
D1  output  4  tens BCD digit, feeds the HEX1 decoder.
Wrap  output  1  one-cycle pulse on the tick that wraps the count.
LoadErr  output  1  one-cycle pulse when a load is rejected.
Tick  output  1  one-cycle prescaler pulse, for chaining further counters.

Behaviour:
- Reset (async, active-high): D0=0, D1=0, prescaler=0, Wrap=0, LoadErr=0, Tick=0. Reset overrides all other inputs.
- Prescaler:
  - Counter runs 0..TICK_DIV-1 while En=1 and holds its value while En=0.
  - Tick is registered and asserts for exactly one cycle on the cycle after the prescaler reaches TICK_DIV-1; the prescaler returns to 0 at the same time.
  - TICK_DIV=1 gives Tick=1 on every cycle while En=1.
- Output invariant: D0 and D1 are always registered, always valid BCD (0..9), and {D1,D0} is always < MODULO.
- Priority in each cycle: Load > tick step > hold.
- Load=1:
  - If LoadVal[3:0] <= 9, LoadVal[7:4] <= 9, and 10*tens + units < MODULO: D1/D0 take LoadVal on the next edge, and the prescaler clears to 0.
  - Otherwise: D1/D0 are unchanged, LoadErr pulses for 1 cycle, and the prescaler still clears.
  - A tick that coincides with Load is discarded; Wrap stays 0.
  - Holding Load=1 reloads on every cycle (or pulses LoadErr on every cycle if the value is invalid).
- Step up (tick, Up=1):
  - If {D1,D0} == MODULO-1: go to 00 and pulse Wrap.
  - Else if D0 == 9: D0=0 and D1=D1+1.
  - Else: D0=D0+1.
- Step down (tick, Up=0):
  - If {D1,D0} == 00: go to MODULO-1 (e.g. MODULO=60 gives 59) and pulse Wrap.
  - Else if D0 == 0: D0=9 and D1=D1-1.
  - Else: D0=D0-1.
- Timing of a step: D0, D1 and Wrap update on the same edge as Tick asserts, so Wrap and Tick are high in the same cycle.
- Latency: a load is visible one cycle after Load is sampled; a count step is visible in the cycle Tick is high.
- En falling mid-period: the prescaler freezes. When En rises again, counting resumes from the frozen prescaler value, with no lost or extra step.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronously). After Reset is released, the first Tick occurs TICK_DIV cycles after the first edge with En=1.
- Up changing between ticks has no effect; only its value on the tick cycle matters.
- No arithmetic is done in binary. The MODULO-1 tens and units digits are computed as constants at elaboration time: MODULO_TENS=(MODULO-1)/10 and MODULO_UNITS=(MODULO-1)%10.

Decomposition:
- Shared package / header constants:
  - BCD_MAX = 4'd9, BCD_ZERO = 4'd0.
  - Helper functions for tens/units of (MODULO-1).
  - A bcd_pair_t pair of 4-bit digits, shared with the display top level.
- One sub-module: tick_gen, parameterised by TICK_DIV, with ports Clock, Reset, En, Clr and Tick. It contains the prescaler and the registered Tick output.
- The digit stepping and load-validation logic stay in bcd_counter2.
- The top level instantiates bcd_counter2 and connects D0→b2d_7seg→HEX0 and D1→b2d_7seg→HEX1.

Test Plan:
- Simulation parameters: TICK_DIV=4, MODULO=60.
- Reset, then En=1, Up=1 → Tick every 4 cycles; sequence 00,01,…,09,10; D0 never shows 10..15.
- Load LoadVal=8'h58, then count up 2 ticks → 59, then 00 with Wrap=1 for one cycle, Wrap and Tick high together.
- Up=0 from 00 → 59 with Wrap; then 50 → 49 (borrow across digits).
- Load 8'h6A, 8'h1C and 8'h60 (each invalid for MODULO=60) → LoadErr pulses 1 cycle each time, D1/D0 unchanged. Load coincident with Tick → loaded value wins, no step, Wrap=0.
- En toggled low for 7 cycles mid-period → Tick spacing is exactly 4 active cycles. Reset asserted between edges → D0=D1=0 immediately; first Tick 4 cycles after release.
- TICK_DIV=1, MODULO=100 → steps every cycle; 99→00 with Wrap; 200 cycles produce exactly 2 Wrap pulses.
